// File: rtl/v810_bus_arb.sv
// Two-port (fetch / data) arbiter in front of the v810_mem internal port.
// Fair tie-break on the last owner; each grant ends on EDACK or after TMO CE cycles.
module v810_bus_arb #(
    parameter int unsigned TMO = 64
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] IA,
    input  logic        IREQ,
    output logic        IACK,
    output logic [31:0] ID,
    input  logic [31:0] DA,
    input  logic [31:0] DWD,
    input  logic [1:0]  DBC,
    input  logic [3:0]  DBE,
    input  logic        DWR,
    input  logic        DREQ,
    output logic [31:0] DRD,
    output logic        DACK,
    output logic [31:0] EDA,
    output logic [31:0] EDD_O,
    output logic [1:0]  EDBC,
    output logic [3:0]  EDBE,
    output logic        EDWR,
    output logic        EDREQ,
    input  logic [31:0] EDD_I,
    input  logic        EDACK,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST_C = 8'(TMO - 1);

    state_t      state_r;
    logic        last_r;
    logic [7:0]  cnt_r;
    logic        hit_tmo_s;
    logic        done_s;

    // Pick the next owner; on a tie the port that did not own the bus last wins.
    function automatic state_t arbitrate(input logic ireq, input logic dreq, input logic last);
        state_t nxt;
        if (ireq && dreq) begin
            nxt = last ? GNT_I : GNT_D;
        end else if (ireq) begin
            nxt = GNT_I;
        end else if (dreq) begin
            nxt = GNT_D;
        end else begin
            nxt = IDLE;
        end
        return nxt;
    endfunction

    // Grant termination: EDACK completes, otherwise the wait counter times out.
    always_comb begin
        hit_tmo_s = (cnt_r == TMO_LAST_C);
        if (CE && !RES && (state_r != IDLE)) begin
            done_s = EDACK || hit_tmo_s;
        end else begin
            done_s = 1'b0;
        end
    end

    // Arbiter FSM, last-owner flag and per-grant wait counter.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= 8'd0;
        end else if (CE) begin
            case (state_r)
                IDLE: begin
                    state_r <= arbitrate(IREQ, DREQ, last_r);
                    cnt_r   <= 8'd0;
                end
                GNT_I: begin
                    if (done_s) begin
                        last_r  <= 1'b0;
                        cnt_r   <= 8'd0;
                        // A timeout always drops EDREQ for a cycle via IDLE.
                        state_r <= EDACK ? arbitrate(1'b0, DREQ, 1'b0) : IDLE;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                GNT_D: begin
                    if (done_s) begin
                        last_r  <= 1'b1;
                        cnt_r   <= 8'd0;
                        state_r <= EDACK ? arbitrate(IREQ, 1'b0, 1'b1) : IDLE;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    // Memory-side request, steered by the current owner.
    always_comb begin
        EDREQ = 1'b0;
        EDA   = 32'd0;
        EDD_O = 32'd0;
        EDBC  = 2'd0;
        EDBE  = 4'd0;
        EDWR  = 1'b0;
        case (state_r)
            GNT_I: begin
                EDREQ = 1'b1;
                EDA   = IA;
                EDBE  = 4'b1111;
                EDBC  = 2'b10;
            end
            GNT_D: begin
                EDREQ = 1'b1;
                EDA   = DA;
                EDD_O = DWD;
                EDBC  = DBC;
                EDBE  = DBE;
                EDWR  = DWR;
            end
            default: begin
                EDREQ = 1'b0;
            end
        endcase
    end

    // Completion strobes and read-data return; a timeout returns zero data.
    always_comb begin
        IACK = done_s && (state_r == GNT_I);
        DACK = done_s && (state_r == GNT_D);
        ERR  = done_s && !EDACK;
        if (IACK && EDACK) begin
            ID = EDD_I;
        end else begin
            ID = 32'd0;
        end
        if (DACK && EDACK) begin
            DRD = EDD_I;
        end else begin
            DRD = 32'd0;
        end
    end

endmodule

// File: tb/tb_v810_bus_arb.sv
// Bench for v810_bus_arb (TMO=4): directed vector table, an alternation
// sequence, then random traffic against an owner/age reference model.
module tb_v810_bus_arb;

    localparam int TMO = 4;

    typedef struct packed {
        logic        res, ce, ireq;
        logic [31:0] ia;
        logic        dreq;
        logic [31:0] da, dwd;
        logic [1:0]  dbc;
        logic [3:0]  dbe;
        logic        dwr, edack;
        logic [31:0] edd_i;
    } stim_t;

    typedef struct packed {
        logic        edreq;
        logic [31:0] eda, edd_o;
        logic [1:0]  edbc;
        logic [3:0]  edbe;
        logic        edwr, iack;
        logic [31:0] id;
        logic        dack;
        logic [31:0] drd;
        logic        err;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t e;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RES, CE, IREQ, DREQ, DWR, EDACK;
    logic [31:0] IA, DA, DWD, EDD_I;
    logic [1:0]  DBC;
    logic [3:0]  DBE;
    logic        IACK, DACK, EDWR, EDREQ, ERR;
    logic [31:0] ID, DRD, EDA, EDD_O;
    logic [1:0]  EDBC;
    logic [3:0]  EDBE;
    resp_t       act;

    int n_cmp = 0;
    int n_bad = 0;
    int m_owner, m_age, m_last;

    v810_bus_arb #(.TMO(TMO)) dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .IA(IA), .IREQ(IREQ), .IACK(IACK), .ID(ID),
        .DA(DA), .DWD(DWD), .DBC(DBC), .DBE(DBE), .DWR(DWR), .DREQ(DREQ),
        .DRD(DRD), .DACK(DACK),
        .EDA(EDA), .EDD_O(EDD_O), .EDBC(EDBC), .EDBE(EDBE), .EDWR(EDWR),
        .EDREQ(EDREQ), .EDD_I(EDD_I), .EDACK(EDACK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    assign act = {EDREQ, EDA, EDD_O, EDBC, EDBE, EDWR, IACK, ID, DACK, DRD, ERR};

    function automatic stim_t st(input logic res, input logic ce, input logic ireq,
                                 input logic [31:0] ia, input logic dreq,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input logic [1:0] dbc, input logic [3:0] dbe,
                                 input logic dwr, input logic edack, input logic [31:0] edd_i);
        return '{res, ce, ireq, ia, dreq, da, dwd, dbc, dbe, dwr, edack, edd_i};
    endfunction

    function automatic resp_t r_idle();
        return '0;
    endfunction

    function automatic resp_t r_gi(input logic [31:0] a, input logic ack,
                                   input logic [31:0] d, input logic err);
        resp_t r = '0;
        r.edreq = 1'b1; r.eda = a; r.edbe = 4'b1111; r.edbc = 2'b10;
        r.iack = ack; r.id = d; r.err = err;
        return r;
    endfunction

    function automatic resp_t r_gd(input logic [31:0] a, input logic [31:0] wd,
                                   input logic [1:0] bc, input logic [3:0] be, input logic wr,
                                   input logic ack, input logic [31:0] d, input logic err);
        resp_t r = '0;
        r.edreq = 1'b1; r.eda = a; r.edd_o = wd; r.edbc = bc; r.edbe = be; r.edwr = wr;
        r.dack = ack; r.drd = d; r.err = err;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        RES = s.res; CE = s.ce; IREQ = s.ireq; IA = s.ia; DREQ = s.dreq;
        DA = s.da; DWD = s.dwd; DBC = s.dbc; DBE = s.dbe; DWR = s.dwr;
        EDACK = s.edack; EDD_I = s.edd_i;
    endtask

    // One clock: drive just after the rising edge, check at the falling edge.
    task automatic run_cycle(input stim_t s, input resp_t e, input bit chk, input string name);
        drive(s);
        @(negedge CLK);
        if (chk) begin
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic int pick(input bit wi, input bit wd, input int last);
        if (wi && wd) return (last == 0) ? 1 : 0;
        if (wi) return 0;
        if (wd) return 1;
        return -1;
    endfunction

    // Reference: owner -1 none, 0 fetch, 1 data; age counts CE cycles in the grant.
    function automatic resp_t model_out(input stim_t s);
        resp_t r = '0;
        bit fin;
        if (m_owner == 0) begin
            r.edreq = 1'b1; r.eda = s.ia; r.edbe = 4'b1111; r.edbc = 2'b10;
        end else if (m_owner == 1) begin
            r.edreq = 1'b1; r.eda = s.da; r.edd_o = s.dwd; r.edbc = s.dbc;
            r.edbe = s.dbe; r.edwr = s.dwr;
        end
        fin = s.ce && !s.res && (m_owner >= 0) && (s.edack || (m_age == TMO - 1));
        if (fin && m_owner == 0) begin
            r.iack = 1'b1; r.id = s.edack ? s.edd_i : 32'd0;
        end
        if (fin && m_owner == 1) begin
            r.dack = 1'b1; r.drd = s.edack ? s.edd_i : 32'd0;
        end
        r.err = fin && !s.edack;
        return r;
    endfunction

    task automatic model_step(input stim_t s);
        bit fin;
        fin = s.ce && !s.res && (m_owner >= 0) && (s.edack || (m_age == TMO - 1));
        if (s.res) begin
            m_owner = -1; m_last = 1; m_age = 0;
        end else if (s.ce) begin
            if (m_owner < 0) begin
                m_owner = pick(s.ireq, s.dreq, m_last); m_age = 0;
            end else if (fin) begin
                m_last = m_owner; m_age = 0;
                if (!s.edack) m_owner = -1;
                else if (m_last == 0) m_owner = pick(1'b0, s.dreq, m_last);
                else m_owner = pick(s.ireq, 1'b0, m_last);
            end else begin
                m_age++;
            end
        end
    endtask

    initial begin
        vec_t  tbl[$];
        stim_t s;
        resp_t e;

        drive(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK); #1;
        run_cycle(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r_idle(), 1'b0, "init");

        // Reset with requests pending, then a single fetch.
        tbl.push_back('{st(1,1,1,32'h100,1,0,0,0,0,0,0,0), r_idle()});
        tbl.push_back('{st(0,1,1,32'h100,0,0,0,0,0,0,0,0), r_idle()});
        tbl.push_back('{st(0,1,1,32'h100,0,0,0,0,0,0,0,0), r_gi(32'h100,0,0,0)});
        tbl.push_back('{st(0,1,1,32'h100,0,0,0,0,0,0,1,32'hDEADBEEF), r_gi(32'h100,1,32'hDEADBEEF,0)});
        tbl.push_back('{st(0,1,0,0,0,0,0,0,0,0,0,0), r_idle()});
        // Data write passthrough.
        tbl.push_back('{st(0,1,0,0,1,32'h70,9,2'b01,4'b0011,1,0,0), r_idle()});
        tbl.push_back('{st(0,1,0,0,1,32'h70,9,2'b01,4'b0011,1,0,0), r_gd(32'h70,9,2'b01,4'b0011,1,0,0,0)});
        tbl.push_back('{st(0,1,0,0,1,32'h70,9,2'b01,4'b0011,1,0,0), r_gd(32'h70,9,2'b01,4'b0011,1,0,0,0)});
        tbl.push_back('{st(0,1,0,0,1,32'h70,9,2'b01,4'b0011,1,1,32'h12345678), r_gd(32'h70,9,2'b01,4'b0011,1,1,32'h12345678,0)});
        tbl.push_back('{st(0,1,0,0,0,0,0,0,0,0,0,0), r_idle()});
        // Timeout after TMO cycles with DREQ held.
        tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_idle()});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,1,0,1)});
        tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_idle()});
        tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        // Reset in the 2nd grant cycle, then a tie goes to fetch.
        tbl.push_back('{st(1,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        tbl.push_back('{st(0,1,1,32'h300,1,32'h200,0,0,4'hF,0,0,0), r_idle()});
        tbl.push_back('{st(0,1,1,32'h300,1,32'h200,0,0,4'hF,0,0,0), r_gi(32'h300,0,0,0)});
        tbl.push_back('{st(0,1,1,32'h300,1,32'h200,0,0,4'hF,0,1,32'hA5), r_gi(32'h300,1,32'hA5,0)});
        // CE=0 freezes the counter and suppresses the ACK.
        tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        tbl.push_back('{st(0,0,0,0,1,32'h200,0,0,4'hF,0,1,32'h77), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        for (int i = 0; i < 2; i++)
            tbl.push_back('{st(0,0,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        for (int i = 0; i < 2; i++)
            tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,0,0,0)});
        tbl.push_back('{st(0,1,0,0,1,32'h200,0,0,4'hF,0,0,0), r_gd(32'h200,0,0,4'hF,0,1,0,1)});
        tbl.push_back('{st(0,1,1,32'h400,0,0,0,0,0,0,0,0), r_idle()});
        tbl.push_back('{st(0,1,1,32'h400,0,0,0,0,0,0,0,0), r_gi(32'h400,0,0,0)});
        tbl.push_back('{st(0,0,1,32'h400,0,0,0,0,0,0,1,32'h55), r_gi(32'h400,0,0,0)});
        tbl.push_back('{st(0,1,1,32'h400,0,0,0,0,0,0,1,32'h55), r_gi(32'h400,1,32'h55,0)});
        tbl.push_back('{st(0,0,0,0,0,0,0,0,0,0,0,0), r_idle()});

        foreach (tbl[i]) run_cycle(tbl[i].s, tbl[i].e, 1'b1, $sformatf("vec%0d", i));

        // Both ports requesting, memory acking every cycle: strict I/D alternation.
        run_cycle(st(1,1,0,0,0,0,0,0,0,0,0,0), r_idle(), 1'b1, "alt_reset");
        run_cycle(st(0,1,1,32'h11,1,32'h22,32'h33,2'b01,4'hC,1,1,32'h44), r_idle(), 1'b1, "alt_idle");
        for (int k = 1; k <= 8; k++) begin
            s = st(0,1,1,32'h11,1,32'h22,32'h33,2'b01,4'hC,1,1,32'h44 + k);
            e = (k % 2 == 1) ? r_gi(32'h11,1,32'h44 + k,0)
                             : r_gd(32'h22,32'h33,2'b01,4'hC,1,1,32'h44 + k,0);
            run_cycle(s, e, 1'b1, $sformatf("alt%0d", k));
        end

        // Random traffic; the first cycle resets DUT and model together.
        m_owner = -1; m_age = 0; m_last = 1;
        s = st(1,1,0,0,0,0,0,0,0,0,0,0);
        run_cycle(s, r_idle(), 1'b0, "rand_reset");
        model_step(s);
        for (int n = 0; n < 1500; n++) begin
            s.res   = ($urandom_range(0, 40) == 0);
            s.ce    = ($urandom_range(0, 3) != 0);
            s.ireq  = 1'($urandom_range(0, 1));
            s.dreq  = 1'($urandom_range(0, 1));
            s.ia    = 32'($urandom);
            s.da    = 32'($urandom);
            s.dwd   = 32'($urandom);
            s.dbc   = 2'($urandom_range(0, 3));
            s.dbe   = 4'($urandom_range(0, 15));
            s.dwr   = 1'($urandom_range(0, 1));
            s.edack = ($urandom_range(0, 4) < 2);
            s.edd_i = 32'($urandom);
            e = model_out(s);
            run_cycle(s, e, 1'b1, "rand");
            model_step(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/v810_bus_arb.md
V810_BUS_ARB -- requirements
Module: v810_bus_arb

Interface
REQ-001 SHALL have parameter TMO, default 64, meaning the number of CE cycles a grant may wait for EDACK before the timeout abort (legal range 2..255).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RES, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port CE, input, 1 bit: clock enable; state advances only on edges where CE=1.
REQ-005 SHALL have fetch-port inputs IA [31:0] (fetch address) and IREQ [1] (fetch request, level).
REQ-006 SHALL have fetch-port outputs IACK [1] (completion strobe) and ID [31:0] (fetch read data).
REQ-007 SHALL have data-port inputs DA [31:0] (address), DWD [31:0] (write data), DBC [1:0] (bus-cycle code), DBE [3:0] (byte enables, active-high), DWR [1] (1=write) and DREQ [1] (request, level).
REQ-008 SHALL have data-port outputs DRD [31:0] (read data) and DACK [1] (completion strobe).
REQ-009 SHALL have memory-side outputs EDA [31:0], EDD_O [31:0] (write data), EDBC [1:0], EDBE [3:0], EDWR [1] and EDREQ [1], driving the v810_mem internal port.
REQ-010 SHALL have memory-side inputs EDD_I [31:0] (read data) and EDACK [1] (completion).
REQ-011 SHALL have output ERR [1]: one-cycle timeout strobe.

Function
REQ-012 SHALL implement an FSM with states IDLE, GNT_I and GNT_D, plus a 1-bit last-owner register LAST (0=I, 1=D).
REQ-013 SHALL sample requests in the same cycle they appear: in IDLE with CE=1, a pending request moves the FSM to its GNT state on the next edge.
REQ-014 SHALL resolve IDLE arbitration as: only IREQ -> GNT_I; only DREQ -> GNT_D; both pending -> the port not equal to LAST; neither -> stay in IDLE.
REQ-015 SHALL, in GNT_I, drive EDREQ=1, EDA=IA, EDWR=0, EDBE=4'b1111, EDBC=2'b10 and EDD_O=0.
REQ-016 SHALL, in GNT_D, drive EDREQ=1 and pass DA, DWD, DBC, DBE and DWR through to EDA, EDD_O, EDBC, EDBE and EDWR.
REQ-017 SHALL, in IDLE, drive EDREQ=0 and all other memory-side outputs to 0.
REQ-018 SHALL complete a grant when EDACK=1 and CE=1 in the GNT state: in that same cycle pulse the owner's ACK combinationally, route EDD_I to ID (owner I) or DRD (owner D), and set LAST to the owner.
REQ-019 SHALL choose the next state on the completion edge with the same rule as REQ-014, so back-to-back grants need no IDLE cycle; the outgoing owner's REQ is ignored in that cycle.
REQ-020 SHALL assert IACK and DACK only when CE=1, never both in one cycle, and each for exactly one CE cycle per grant.
REQ-021 SHALL hold ID and DRD at 0 except in their port's ACK cycle.
REQ-022 SHALL hold a grant until EDACK or timeout even if the owner drops its REQ early; requesters hold attributes stable until ACK.
REQ-023 SHALL count CE cycles in each GNT state with an 8-bit counter that clears on grant entry.
REQ-024 SHALL abort the grant when the counter reaches TMO-1 with no EDACK: pulse the owner's ACK with read data 0, pulse ERR, update LAST, and drop EDREQ for at least one cycle by returning to IDLE.
REQ-025 SHALL give EDACK priority over timeout when both occur in the same cycle: normal completion, ERR=0.
REQ-026 SHALL freeze all state and the counter when CE=0 and drive IACK=DACK=ERR=0.

Reset
REQ-027 SHALL, on RES=1 at a clock edge (regardless of CE), enter IDLE with LAST=1 (so the fetch port wins the first tie), counter=0, and all outputs 0 from the next cycle.
REQ-028 SHALL abandon an in-flight grant without an ACK when RES is asserted mid-grant, and drop EDREQ on the next edge.
REQ-029 SHALL ignore IREQ/DREQ while RES=1.

Verification
REQ-030 SHALL cover: IREQ alone, IA=0x100, memory acks on the 2nd grant cycle with EDD_I=0xDEADBEEF -> EDREQ high 2 cycles, EDA=0x100, EDBE=1111, IACK for 1 cycle with ID=0xDEADBEEF, then IDLE.
REQ-031 SHALL cover: IREQ and DREQ raised together after reset, memory acking in the same cycle -> grant order I, D, I, D...; no IDLE cycle between grants; IACK/DACK never coincident.
REQ-032 SHALL cover: data write DA=0x70, DWD=9, DBE=0011, DWR=1 -> EDA=0x70, EDD_O=9, EDBE=0011, EDWR=1 until EDACK, then DACK for 1 cycle.
REQ-033 SHALL cover: TMO=4, no EDACK -> EDREQ high exactly 4 cycles; DACK and ERR pulse together in the 4th cycle with DRD=0; EDREQ low the next cycle.
REQ-034 SHALL cover: RES raised in the 2nd cycle of a GNT_D grant -> no DACK; EDREQ=0 after that edge; the next tie grants fetch first.
REQ-035 SHALL cover: CE toggling 1,0,1 during a grant with EDACK held high -> ACK only in the CE=1 cycle; the counter does not advance in CE=0 cycles.
